// File: rtl/led_fader.sv
// Per-channel LED fader: each LED ramps linearly toward its commanded on/off
// brightness on a prescaled step tick and is driven as PWM against a free-running counter.
module led_fader #(
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy,
    output logic                settled
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        CH_OFF      = 3'd0,
        CH_FALLING  = 3'd1,
        CH_ON       = 3'd2,
        CH_RISING   = 3'd3,
        CH_LOWERING = 3'd4
    } ch_state_e;

    logic [NUM_LEDS-1:0] pattern_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                step_tick_s;
    logic [PWM_BITS-1:0] level_q [NUM_LEDS];
    logic [PWM_BITS-1:0] level_d [NUM_LEDS];
    ch_state_e           ch_state_s [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                busy_q, busy_d;
    logic                settled_q, settled_d;

    // Channel state is a pure function of the registered target and current level.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            ch_state_s[i] = CH_OFF;
            if (!pattern_q[i]) begin
                if (level_q[i] == {PWM_BITS{1'b0}}) begin
                    ch_state_s[i] = CH_OFF;
                end else begin
                    ch_state_s[i] = CH_FALLING;
                end
            end else if (level_q[i] == max_level) begin
                ch_state_s[i] = CH_ON;
            end else if (level_q[i] < max_level) begin
                ch_state_s[i] = CH_RISING;
            end else begin
                ch_state_s[i] = CH_LOWERING;
            end
        end
    end

    // Next-state for counters, levels and the registered outputs.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        step_tick_s = (div_cnt_q == DIV_LAST);
        if (step_tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        busy_d = 1'b0;
        led_d  = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            level_d[i] = level_q[i];
            led_d[i]   = enable & (level_q[i] > pwm_cnt_q);
            // Steps of one toward the target can never overshoot, so no wrap is possible.
            case (ch_state_s[i])
                CH_RISING: begin
                    busy_d = 1'b1;
                    if (step_tick_s) begin
                        level_d[i] = level_q[i] + PWM_BITS'(1);
                    end else begin
                        level_d[i] = level_q[i];
                    end
                end
                CH_FALLING, CH_LOWERING: begin
                    busy_d = 1'b1;
                    if (step_tick_s) begin
                        level_d[i] = level_q[i] - PWM_BITS'(1);
                    end else begin
                        level_d[i] = level_q[i];
                    end
                end
                default: begin
                    level_d[i] = level_q[i];
                end
            endcase
        end
        settled_d = busy_q & ~busy_d;
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= {NUM_LEDS{1'b0}};
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            div_cnt_q <= {DIV_W{1'b0}};
            led_q     <= {NUM_LEDS{1'b0}};
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_q[i] <= {PWM_BITS{1'b0}};
            end
        end else begin
            pattern_q <= pattern_in;
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            settled_q <= settled_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign settled = settled_q;

endmodule
